vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator: a single block that replaces separate horizontal/vertical counters with one coherent H/V counter pair plus registered sync, blanking and frame/line strobes. It sits directly behind the pixel clock domain and drives the sync pins and the pixel-fetch logic. Geometry, sync polarity and counter width are compile-time parameters, so any standard mode can be generated without RTL edits. A pixel-clock enable allows running from a faster system clock.

## Interface

- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: hsync pulse width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vsync pulse width, lines
- V_BP, 33: vertical back porch, lines
- H_SYNC_POL, 0: hsync asserted level (0 = active-low)
- V_SYNC_POL, 0: vsync asserted level (0 = active-low)
- CNT_W, 16: counter width; must satisfy 2^CNT_W > max(H_TOTAL-1, V_TOTAL-1)

Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Every geometry parameter is at least 1.

- clk_25MHz  in  1  pixel/system clock
- rst_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel advance enable; tie high for one pixel per clock
- h_count  out  CNT_W  current column, 0..H_TOTAL-1
- v_count  out  CNT_W  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync at H_SYNC_POL when asserted
- vsync  out  1  vertical sync at V_SYNC_POL when asserted
- video_on  out  1  high when h_count < H_ACTIVE and v_count < V_ACTIVE
- line_start  out  1  one-clock strobe: h_count just became 0
- frame_start  out  1  one-clock strobe: (h_count, v_count) just became (0, 0)

## Operation

- All outputs are registered. hsync, vsync and video_on always describe the current h_count/v_count value (computed from next-state counts), so there is no extra pipeline skew.
- On each rising edge with pix_en=1: if h_count = H_TOTAL-1, h_count <= 0 and v_count advances; otherwise h_count increments. v_count advances as (v_count = V_TOTAL-1) ? 0 : v_count+1.
- Line period is exactly H_TOTAL enabled cycles. Frame period is exactly H_TOTAL*V_TOTAL enabled cycles. No extra count state exists.
- With pix_en=0, counters and hsync/vsync/video_on hold. line_start and frame_start clear.
- hsync is asserted for H_ACTIVE+H_FP <= h_count <= H_ACTIVE+H_FP+H_SYNC-1; otherwise it sits at the inverse of H_SYNC_POL.
- vsync is asserted for V_ACTIVE+V_FP <= v_count <= V_ACTIVE+V_FP+V_SYNC-1. It is line-granular and changes coincident with h_count wrapping to 0.
- line_start goes high for one clk_25MHz cycle after the enabled edge that loads h_count=0. frame_start is the same, but only when v_count is also loaded with 0. Both fire together at frame wrap.

## Timing

- Reset (rst_n low, asynchronous, any time, including mid-frame): h_count=H_TOTAL-1, v_count=V_TOTAL-1, video_on=0, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL, line_start=0, frame_start=0. This is the coherent last pixel of the back porch.
- Reset release: the first enabled edge loads (0,0), sets video_on=1 and asserts line_start and frame_start for one clock. Pixel 0 of the first frame is never skipped.
- Latency from counter change to sync/blank/strobe: 0 cycles; all are updated on the same edge.
- Default mode, pix_en=1: hsync low at h_count 656..751; vsync low at v_count 490..491; 800 clocks per line; 420000 clocks per frame.

## Test plan

- Reset mid-frame at (h=300, v=200), release: outputs equal reset values immediately. The first clock gives h=0, v=0, video_on=1, line_start=frame_start=1. The next clock gives h=1 with both strobes 0.
- Default mode, pix_en=1, run 2 frames: line_start every 800 clocks, frame_start every 420000 clocks. h_count never exceeds 799; v_count never exceeds 524.
- Default mode: hsync falls at h=656, rises at h=752 (96 clocks). vsync is low exactly for lines 490..491 and changes on the edge where h_count=0. video_on falls at h=640 and at v=480.
- pix_en toggling 1,0,0,1 across the h=799 -> 0 wrap: counts and syncs hold through the low cycles. line_start is a single one-clock pulse after the wrap edge.
- Alternate mode 800x600 (H 800/40/128/88, V 600/1/4/23, both polarities 1): line = 1056 clocks, frame = 628 lines. hsync high at h=840..967; vsync high at v=601..604.
- Minimal geometry (all porches/sync = 1, H_ACTIVE=V_ACTIVE=2, CNT_W=3): line = 5, frame = 5 lines. Check the wrap and that the strobes coincide at frame wrap.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: the raster bundle. The generator drives the counts, syncs and strobes.
// The consumer side drives the pixel-advance enable.
interface vga_timing_gen_if #(
  parameter int CNT_W = 16
);
  logic             pix_en;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic             line_start;
  logic             frame_start;
  modport master (
    input  pix_en,
    output h_count, v_count, hsync, vsync, video_on, line_start, frame_start
  );
  modport slave (
    output pix_en,
    input  h_count, v_count, hsync, vsync, video_on, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster H/V counter pair with registered sync, blanking
// and line/frame strobes. Every output is decoded from the next-state counts, so all outputs stay aligned.
module vga_timing_gen #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   CNT_W      = 16
) (
  input logic              clk_25MHz,
  input logic              rst_n,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [CNT_W-1:0] r_h_count;
  logic [CNT_W-1:0] r_v_count;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic             r_line_start;
  logic             r_frame_start;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;
  always_comb begin
    w_h_wrap = r_h_count == H_LAST;
    w_v_wrap = r_v_count == V_LAST;
    w_h_next = w_h_wrap ? '0 : r_h_count + CNT_W'(1);
    w_v_next = !w_h_wrap ? r_v_count : w_v_wrap ? '0 : r_v_count + CNT_W'(1);
  end
  // Reset parks the raster on the last back-porch pixel, so the first enabled edge opens frame 0.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_h_count     <= H_LAST;
      r_v_count     <= V_LAST;
      r_hsync       <= ~H_SYNC_POL;
      r_vsync       <= ~V_SYNC_POL;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (vga.pix_en) begin
      r_h_count     <= w_h_next;
      r_v_count     <= w_v_next;
      r_hsync       <= (w_h_next >= HS_BEG && w_h_next <= HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
      r_vsync       <= (w_v_next >= VS_BEG && w_v_next <= VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
      r_video_on    <= w_h_next < H_ACT && w_v_next < V_ACT;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap && w_v_wrap;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end
  assign vga.h_count     = r_h_count;
  assign vga.v_count     = r_v_count;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.video_on    = r_video_on;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;
endmodule
